// File: rtl/signed_sort4.sv
`default_nettype none
// ============================================================================
// Module   : signed_sort4
// Brief    : Loads four signed operands, bubble-sorts them ascending with one
//            compare/swap per cycle and early exit, then drains smallest first.
// Revision : 1.0
// ============================================================================
module signed_sort4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SORT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] C_LAST_IDX  = 2'd3;
    localparam logic [1:0] C_LAST_PAIR = 2'd2;
    localparam logic [1:0] C_MAX_PASS  = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [W-1:0] r_buf [0:3];
    logic [1:0]   r_idx;
    logic [1:0]   r_j;
    logic [1:0]   r_pass;
    logic         r_swapped;

    logic         w_load_fire;
    logic         w_drain_fire;
    logic [W-1:0] w_lo;
    logic [W-1:0] w_hi;
    logic         w_gt;
    logic         w_pass_end;
    logic         w_sort_done;

    // Only the current adjacent pair is compared; j never exceeds 2.
    assign w_lo         = r_buf[r_j];
    assign w_hi         = r_buf[r_j + 2'd1];
    assign w_gt         = $signed(w_lo) > $signed(w_hi);
    assign w_load_fire  = (r_state == S_LOAD) && in_valid;
    assign w_drain_fire = (r_state == S_DRAIN) && out_ready;
    assign w_pass_end   = (r_state == S_SORT) && (r_j == C_LAST_PAIR);
    // A clean pass (including this cycle's compare) or the third pass ends sorting.
    assign w_sort_done  = w_pass_end && (!(r_swapped || w_gt) || (r_pass == C_MAX_PASS));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_load_fire && (r_idx == C_LAST_IDX)) begin
                    w_next_state = S_SORT;
                end
            end
            S_SORT: begin
                if (w_sort_done) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_fire && (r_idx == C_LAST_IDX)) begin
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
            end
            S_SORT: begin
                busy = 1'b1;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = r_buf[r_idx];
                out_last  = (r_idx == C_LAST_IDX);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Buffer, indices and swap bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r_buf[k] <= '0;
            end
            r_idx     <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_fire) begin
                        r_buf[r_idx] <= in_data;
                        r_idx        <= r_idx + 2'd1;
                        if (r_idx == C_LAST_IDX) begin
                            r_j       <= 2'd0;
                            r_pass    <= 2'd1;
                            r_swapped <= 1'b0;
                        end
                    end
                end
                S_SORT: begin
                    // Strict greater-than only, so equal keys keep arrival order.
                    if (w_gt) begin
                        r_buf[r_j]        <= w_hi;
                        r_buf[r_j + 2'd1] <= w_lo;
                    end
                    if (w_sort_done) begin
                        r_idx <= 2'd0;
                        r_j   <= 2'd0;
                    end else if (w_pass_end) begin
                        r_pass    <= r_pass + 2'd1;
                        r_j       <= 2'd0;
                        r_swapped <= 1'b0;
                    end else begin
                        r_j       <= r_j + 2'd1;
                        r_swapped <= r_swapped | w_gt;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_fire) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signed_sort4.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_sort4
// Brief    : Directed self-checking bench for signed_sort4 (W=4).
// Revision : 1.0
// ============================================================================
module tb_signed_sort4;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    int    checks;
    int    errors;
    string grp;

    signed_sort4 #(.W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", grp, tag, obs, exp);
        end
    endtask

    // Offers four operands back to back; returns at the negedge of cycle t+1.
    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        logic [15:0] v;
        v = {d, c, b, a};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = v[i*4 +: 4];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    // Counts SORT cycles until the first out_valid and checks that count.
    task automatic wait_sort(input int exp_c);
        int c;
        c = 0;
        while (!out_valid && c < 20) begin
            chk("busy_sort", {31'd0, busy}, 32'd1);
            chk("in_ready_sort", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            c++;
        end
        chk("compare_cycles", c, exp_c);
    endtask

    // Drains with the given out_ready pattern (bit p used on drain cycle p).
    task automatic drain4(input logic [15:0] e, input logic [31:0] pat);
        int k;
        int p;
        k = 0;
        p = 0;
        while (k < 4 && p < 32) begin
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_data", {28'd0, out_data}, {28'd0, e[k*4 +: 4]});
            chk("out_last", {31'd0, out_last}, {31'd0, (k == 3)});
            chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
            out_ready = pat[p];
            if (pat[p]) k++;
            p++;
            @(negedge clk);
        end
        chk("transfers", k, 4);
        out_ready = 1'b0;
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;

        grp = "reset";
        repeat (2) @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, 32'd0);
        chk("out_last", {31'd0, out_last}, 32'd0);
        chk("out_data", {28'd0, out_data}, 32'd0);
        chk("busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, 32'd1);

        // 4,-1,7,-8 -> -8,-1,4,7 with nine compare cycles
        grp = "mixed";
        load4(4'h4, 4'hF, 4'h7, 4'h8);
        wait_sort(9);
        drain4({4'h7, 4'h4, 4'hF, 4'h8}, 32'hFFFF_FFFF);

        // -8,-3,0,7 already ascending; in_valid during SORT must be ignored
        grp = "sorted";
        load4(4'h8, 4'hD, 4'h0, 4'h7);
        in_valid = 1'b1;
        in_data  = 4'h5;
        wait_sort(3);
        in_valid = 1'b0;
        in_data  = 4'h0;
        drain4({4'h7, 4'h0, 4'hD, 4'h8}, 32'hFFFF_FFFF);

        // 7,3,0,-8 strictly descending -> worst case
        grp = "descending";
        load4(4'h7, 4'h3, 4'h0, 4'h8);
        wait_sort(9);
        drain4({4'h7, 4'h3, 4'h0, 4'h8}, 32'hFFFF_FFFF);

        // 2,-5,2,-5 with duplicates and out_ready 1,0,0,1,1,0,1
        grp = "dup_backpressure";
        load4(4'h2, 4'hB, 4'h2, 4'hB);
        wait_sort(9);
        drain4({4'h2, 4'h2, 4'hB, 4'hB}, 32'hFFFF_FFD9);

        // 0,-8,-1,7: unsigned ordering would give 0,7,-8,-1
        grp = "signed_bounds";
        load4(4'h0, 4'h8, 4'hF, 4'h7);
        wait_sort(6);
        drain4({4'h7, 4'h0, 4'hF, 4'h8}, 32'hFFFF_FFFF);

        // Reset two cycles into SORT aborts the group
        grp = "abort";
        load4(4'h7, 4'h3, 4'h0, 4'h8);
        @(negedge clk);
        reset = 1'b1;
        chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("busy_after_rst", {31'd0, busy}, 32'd0);
        chk("out_valid_after_rst", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        load4(4'h1, 4'h0, 4'h3, 4'h2);
        wait_sort(6);
        drain4({4'h3, 4'h2, 4'h1, 4'h0}, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
